// File: rtl/cim_host_pkg.sv
// Shared encodings for the CIM host sequencer: macro op codes and FSM states.
package cim_host_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_CIM = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/cim_host_sequencer_serializer.sv
// Activation bit-plane serializer: latches activations and presents one
// MSB-first bit-plane per row, stepping on adv and rewinding on msb.
module cim_bitplane_serializer #(
  parameter int N_ROWS  = 64,
  parameter int IN_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [N_ROWS*IN_BITS-1:0] act,
  input  logic                      adv,
  input  logic                      msb,
  output logic [N_ROWS-1:0]         plane
);

  localparam int IDX_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_BITS - 1);

  logic [N_ROWS*IN_BITS-1:0] act_q, act_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N_ROWS-1:0]         plane_q, plane_d;
  logic [IN_BITS-1:0]        row_s;

  // Next plane index and the plane it selects; load beats msb beats adv.
  always_comb begin
    act_d   = act_q;
    idx_d   = idx_q;
    plane_d = '0;
    row_s   = '0;
    if (load) begin
      act_d = act;
      idx_d = '0;
    end else if (msb) begin
      idx_d = '0;
    end else if (adv && (idx_q != IDX_LAST)) begin
      idx_d = idx_q + 1'b1;
    end else begin
      idx_d = idx_q;
    end
    // Left-shifting by the index brings bit (IN_BITS-1-k) to the top.
    for (int r = 0; r < N_ROWS; r++) begin
      row_s      = act_d[IN_BITS*r +: IN_BITS] << idx_d;
      plane_d[r] = row_s[IN_BITS-1];
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q   <= '0;
      idx_q   <= '0;
      plane_q <= '0;
    end else begin
      act_q   <= act_d;
      idx_q   <= idx_d;
      plane_q <= plane_d;
    end
  end

  assign plane = plane_q;

endmodule

// File: rtl/cim_host_sequencer.sv
// Host-side sequencer for a compute-in-memory macro: accepts one command,
// drives the macro handshake with start/busy timeouts, returns one response.
module cim_host_sequencer
  import cim_host_pkg::*;
#(
  parameter int N_ROWS   = 64,
  parameter int IN_BITS  = 4,
  parameter int DATA_W   = 64,
  parameter int START_TO = 8,
  parameter int BUSY_TO  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [5:0]                cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  input  logic [N_ROWS*IN_BITS-1:0] cmd_act,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      start,
  output logic [1:0]                r_w_cim,
  output logic [5:0]                wl_addr,
  output logic [DATA_W-1:0]         din,
  output logic [N_ROWS-1:0]         cim_in,
  input  logic                      busy,
  input  logic                      rd_data_enable,
  input  logic                      cim_data_enable,
  input  logic                      in_msb,
  input  logic [DATA_W-1:0]         macro_data
);

  localparam int SC_W = $clog2(START_TO) + 1;
  localparam int BC_W = $clog2(BUSY_TO) + 1;
  localparam logic [SC_W-1:0] START_LAST = SC_W'(START_TO - 1);
  localparam logic [BC_W-1:0] BUSY_LAST  = BC_W'(BUSY_TO - 1);

  state_t              state_q, state_d;
  logic [1:0]          r_w_cim_q, r_w_cim_d;
  logic [5:0]          wl_addr_q, wl_addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   rd_word_q, rd_word_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [SC_W-1:0]     start_cnt_q, start_cnt_d;
  logic [BC_W-1:0]     busy_cnt_q, busy_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                start_q, start_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                ser_load_s;
  logic [N_ROWS*IN_BITS-1:0] ser_act_s;
  logic                ser_adv_s, ser_msb_s;

  // Next-state, datapath capture and registered-output decode.
  always_comb begin
    state_d     = state_q;
    r_w_cim_d   = r_w_cim_q;
    wl_addr_d   = wl_addr_q;
    din_d       = din_q;
    rd_word_d   = rd_word_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    start_cnt_d = start_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    ser_load_s  = 1'b0;
    ser_act_s   = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && (cmd_op != OP_NOP)) begin
          state_d    = S_ISSUE;
          r_w_cim_d  = cmd_op;
          wl_addr_d  = cmd_addr;
          din_d      = cmd_wdata;
          rd_word_d  = '0;
          ser_load_s = 1'b1;
          ser_act_s  = (cmd_op == OP_CIM) ? cmd_act : '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d     = S_WAIT_BUSY;
        start_cnt_d = '0;
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          state_d    = S_RUN;
          busy_cnt_d = '0;
        end else if (start_cnt_q == START_LAST) begin
          state_d    = S_RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (rd_data_enable) begin
          rd_word_d = macro_data;
        end else begin
          rd_word_d = rd_word_q;
        end
        if (!busy) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b0;
          case (r_w_cim_q)
            OP_CIM:  rsp_data_d = macro_data;
            OP_RD:   rsp_data_d = rd_word_d;
            default: rsp_data_d = '0;
          endcase
        end else if (busy_cnt_q == BUSY_LAST) begin
          state_d    = S_RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d    = S_IDLE;
          r_w_cim_d  = OP_NOP;
          ser_load_s = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    start_d     = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_w_cim_q   <= OP_NOP;
      wl_addr_q   <= '0;
      din_q       <= '0;
      rd_word_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      start_cnt_q <= '0;
      busy_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_w_cim_q   <= r_w_cim_d;
      wl_addr_q   <= wl_addr_d;
      din_q       <= din_d;
      rd_word_q   <= rd_word_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      start_cnt_q <= start_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Macro strobes seen while idle belong to nobody and must not move the plane.
  assign ser_adv_s = cim_data_enable && (state_q != S_IDLE);
  assign ser_msb_s = in_msb && (state_q != S_IDLE);

  cim_bitplane_serializer #(
    .N_ROWS  (N_ROWS),
    .IN_BITS (IN_BITS)
  ) u_serializer (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load_s),
    .act   (ser_act_s),
    .adv   (ser_adv_s),
    .msb   (ser_msb_s),
    .plane (cim_in)
  );

  assign cmd_ready = cmd_ready_q;
  assign start     = start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign r_w_cim   = r_w_cim_q;
  assign wl_addr   = wl_addr_q;
  assign din       = din_q;

endmodule
